// File: rtl/ysyx22041405_ifu_pkg.sv
// ysyx22041405_ifu_pkg
//   Shared definitions for the instruction fetch unit:
//   - ifu_state_t      : fetch FSM state encoding
//   - RESET_PC_DEFAULT : architectural PC after reset
//   - INST_LEN         : instruction length in bytes (fixed-length ISA)
//   - is_misaligned    : true when a target address is not word aligned
package ysyx22041405_ifu_pkg;

  typedef enum logic [2:0] {
    ST_REQ  = 3'd0,  // request to imem outstanding
    ST_WAIT = 3'd1,  // request accepted, waiting for the response
    ST_HOLD = 3'd2,  // instruction offered to decode
    ST_EXEC = 3'd3,  // instruction executing, waiting for retire
    ST_HALT = 3'd4   // fault seen, frozen until reset
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          INST_LEN         = 4;

  // Instructions are 4-byte aligned; any set bit in [1:0] is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx22041405_pc_reg.sv
// ysyx22041405_pc_reg
//   Architectural PC register with load enable and asynchronous reset.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset, loads RESET_VAL
//     load  : capture d on the next rising edge
//     d     : new PC value
//     q     : current PC value
module ysyx22041405_pc_reg #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx22041405_ifu.sv
// ysyx22041405_ifu
//   Instruction fetch unit. Owns the architectural PC, fetches exactly one
//   instruction at a time from instruction memory, offers it to decode and
//   waits for the instruction to retire before loading the next PC.
//
//   Handshakes: a transfer happens on a rising edge where both valid and
//   ready are high; valid, once raised, stays high with stable payload until
//   that transfer. The imem response is a single-cycle valid pulse with no
//   ready and is only consumed in WAIT.
//
//   Ports:
//     clk, rst_n       : clock (rising edge), async active-low reset
//     next_pc          : next PC from the branch unit, qualified by wb_valid
//     wb_valid         : current instruction retired this cycle
//     imem_req_valid   : fetch request valid          (out)
//     imem_req_ready   : memory accepts the request   (in)
//     imem_addr        : fetch address, equal to pc   (out)
//     imem_rsp_valid   : response pulse               (in)
//     imem_rsp_data    : instruction word             (in)
//     imem_rsp_err     : access fault on response     (in)
//     inst_valid       : instruction valid to decode  (out)
//     inst_ready       : decode accepts instruction   (in)
//     inst             : latched instruction word     (out)
//     pc, pc_add4      : current PC and PC+4 (wraps)  (out)
//     fetch_err        : sticky fault flag            (out)
//     dbg_state        : current FSM state encoding   (out)
module ysyx22041405_ifu
  import ysyx22041405_ifu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             wb_valid,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             imem_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_add4,
  output logic             fetch_err,
  output logic [2:0]       dbg_state
);

  ifu_state_t       state;
  logic             req_valid_q;
  logic             inst_valid_q;
  logic [WIDTH-1:0] inst_q;
  logic             fetch_err_q;

  logic             req_fire;
  logic             inst_fire;
  logic             retire;
  logic             target_bad;
  logic             pc_load;

  assign req_fire   = req_valid_q && imem_req_ready;
  assign inst_fire  = inst_valid_q && inst_ready;
  assign retire     = (state == ST_EXEC) && wb_valid;
  assign target_bad = is_misaligned(next_pc[1:0]);
  // A misaligned target leaves the PC pointing at the faulting instruction.
  assign pc_load    = retire && !target_bad;

  ysyx22041405_pc_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (next_pc),
    .q     (pc)
  );

  // Fetch FSM. The valids are registers updated together with the state so
  // they never depend combinationally on any input. After reset the FSM
  // sits in REQ with the request valid low for one cycle; the first clock
  // after release raises it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_REQ;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_fire) begin
            state       <= ST_WAIT;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end

        // Only reachable one edge after the request handshake, so a
        // response in the handshake cycle itself is never taken.
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fetch_err_q <= 1'b1;
              state       <= ST_HALT;
            end else begin
              inst_q       <= imem_rsp_data;
              inst_valid_q <= 1'b1;
              state        <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (inst_fire) begin
            inst_valid_q <= 1'b0;
            state        <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (wb_valid) begin
            if (target_bad) begin
              fetch_err_q <= 1'b1;
              state       <= ST_HALT;
            end else begin
              req_valid_q <= 1'b1;
              state       <= ST_REQ;
            end
          end
        end

        ST_HALT: begin
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end

        // Unused encodings park the unit safely.
        default: begin
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          state        <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign pc_add4        = pc + WIDTH'(INST_LEN);
  assign fetch_err      = fetch_err_q;
  assign dbg_state      = state;

endmodule
